// File: rtl/id_ex_if.sv
// Decode/writeback/control inputs and execute-stage outputs of the ID/EX pipeline register.
// The master side (decode logic) drives the inputs, and the stage implements the slave side.
interface id_ex_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
);
    logic              valid_d;
    logic [XLEN-1:0]   pc_d;
    logic [4:0]        rs1_d;
    logic [4:0]        rs2_d;
    logic              uses_rs1_d;
    logic              uses_rs2_d;
    logic [4:0]        rd_d;
    logic              w_en_d;
    logic              mem_rd_d;
    logic [XLEN-1:0]   rs1_data_d;
    logic [XLEN-1:0]   rs2_data_d;
    logic [XLEN-1:0]   imm_d;
    logic [CTRL_W-1:0] ctrl_d;

    logic [4:0]        wb_idx_w;
    logic              w_en_w;
    logic [XLEN-1:0]   wb_data_w;

    logic              flush;
    logic              stall_ext;

    logic              valid_e;
    logic [XLEN-1:0]   pc_e;
    logic [4:0]        rs1_e;
    logic [4:0]        rs2_e;
    logic [4:0]        rd_e;
    logic              w_en_e;
    logic              mem_rd_e;
    logic [XLEN-1:0]   rs1_data_e;
    logic [XLEN-1:0]   rs2_data_e;
    logic [XLEN-1:0]   imm_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic              stall_fd;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output valid_d, pc_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d, rd_d, w_en_d, mem_rd_d,
               rs1_data_d, rs2_data_d, imm_d, ctrl_d, wb_idx_w, w_en_w, wb_data_w,
               flush, stall_ext,
        input  valid_e, pc_e, rs1_e, rs2_e, rd_e, w_en_e, mem_rd_e, rs1_data_e, rs2_data_e,
               imm_e, ctrl_e, stall_fd, stall_cnt, flush_cnt
    );

    modport slave (
        input  valid_d, pc_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d, rd_d, w_en_d, mem_rd_d,
               rs1_data_d, rs2_data_d, imm_d, ctrl_d, wb_idx_w, w_en_w, wb_data_w,
               flush, stall_ext,
        output valid_e, pc_e, rs1_e, rs2_e, rd_e, w_en_e, mem_rd_e, rs1_data_e, rs2_data_e,
               imm_e, ctrl_e, stall_fd, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, external freeze,
// writeback-to-decode operand bypass, and stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic   clk,
    input  logic   rst,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              w_en;
        logic              mem_rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    typedef enum logic [1:0] {ACT_HOLD, ACT_FLUSH, ACT_BUBBLE, ACT_LOAD} act_t;

    ex_t              ex_q;
    ex_t              ex_load;
    act_t             act;
    logic             luh;
    logic             wb_hit1;
    logic             wb_hit2;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // A load whose rd is still in execute cannot be forwarded yet, so a reader must wait a cycle.
    assign luh = ex_q.valid & ex_q.mem_rd & ex_q.w_en & bus.valid_d &
                 ((bus.uses_rs1_d & (bus.rs1_d == ex_q.rd)) |
                  (bus.uses_rs2_d & (bus.rs2_d == ex_q.rd)));

    assign wb_hit1 = bus.w_en_w & (bus.wb_idx_w != 5'd0) & (bus.wb_idx_w == bus.rs1_d);
    assign wb_hit2 = bus.w_en_w & (bus.wb_idx_w != 5'd0) & (bus.wb_idx_w == bus.rs2_d);

    always_comb begin
        act = ACT_LOAD;
        if (bus.stall_ext)  act = ACT_HOLD;
        else if (bus.flush) act = ACT_FLUSH;
        else if (luh)       act = ACT_BUBBLE;
    end

    always_comb begin
        ex_load          = '0;
        ex_load.valid    = bus.valid_d;
        ex_load.pc       = bus.pc_d;
        ex_load.rs1      = bus.uses_rs1_d ? bus.rs1_d : 5'd0;
        ex_load.rs2      = bus.uses_rs2_d ? bus.rs2_d : 5'd0;
        ex_load.rd       = bus.rd_d;
        ex_load.w_en     = bus.valid_d & bus.w_en_d & (bus.rd_d != 5'd0);
        ex_load.mem_rd   = bus.valid_d & bus.mem_rd_d;
        ex_load.rs1_data = wb_hit1 ? bus.wb_data_w : bus.rs1_data_d;
        ex_load.rs2_data = wb_hit2 ? bus.wb_data_w : bus.rs2_data_d;
        ex_load.imm      = bus.imm_d;
        ex_load.ctrl     = bus.ctrl_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (act)
                ACT_HOLD: ;
                ACT_FLUSH: begin
                    ex_q        <= '0;
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                end
                ACT_BUBBLE: begin
                    ex_q        <= '0;
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                default: ex_q <= ex_load;
            endcase
        end
    end

    // Deliberately independent of the writeback port so the bypass never lengthens this path.
    assign bus.stall_fd   = bus.stall_ext | (~bus.flush & luh);

    assign bus.valid_e    = ex_q.valid;
    assign bus.pc_e       = ex_q.pc;
    assign bus.rs1_e      = ex_q.rs1;
    assign bus.rs2_e      = ex_q.rs2;
    assign bus.rd_e       = ex_q.rd;
    assign bus.w_en_e     = ex_q.w_en;
    assign bus.mem_rd_e   = ex_q.mem_rd;
    assign bus.rs1_data_e = ex_q.rs1_data;
    assign bus.rs2_data_e = ex_q.rs2_data;
    assign bus.imm_e      = ex_q.imm;
    assign bus.ctrl_e     = ex_q.ctrl;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus a randomized run checked against a cycle-level reference model.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    id_ex_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();
    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.valid_d = 0; bus.pc_d = 0; bus.rs1_d = 0; bus.rs2_d = 0;
        bus.uses_rs1_d = 0; bus.uses_rs2_d = 0; bus.rd_d = 0; bus.w_en_d = 0;
        bus.mem_rd_d = 0; bus.rs1_data_d = 0; bus.rs2_data_d = 0; bus.imm_d = 0;
        bus.ctrl_d = 0; bus.wb_idx_w = 0; bus.w_en_w = 0; bus.wb_data_w = 0;
        bus.flush = 0; bus.stall_ext = 0;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                           input logic wen, input logic mrd);
        bus.valid_d = v; bus.rs1_d = r1; bus.uses_rs1_d = u1; bus.rs2_d = r2;
        bus.uses_rs2_d = u2; bus.rd_d = rd; bus.w_en_d = wen; bus.mem_rd_d = mrd;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        bus.valid_d = 1; bus.pc_d = $urandom; bus.rs1_d = 5'($urandom); bus.rs2_d = 5'($urandom);
        bus.uses_rs1_d = 1; bus.uses_rs2_d = 1; bus.rd_d = 5'($urandom); bus.w_en_d = 1;
        bus.mem_rd_d = 1; bus.rs1_data_d = $urandom; bus.rs2_data_d = $urandom;
        bus.imm_d = $urandom; bus.ctrl_d = 16'($urandom); bus.wb_idx_w = 5'($urandom);
        bus.w_en_w = 1; bus.wb_data_w = $urandom; bus.flush = 1'($urandom); bus.stall_ext = 1'($urandom);
        rst = 1; tick(); tick();
        checks++;
        if ({bus.valid_e, bus.pc_e, bus.rs1_e, bus.rs2_e, bus.rd_e, bus.w_en_e, bus.mem_rd_e,
             bus.rs1_data_e, bus.rs2_data_e, bus.imm_e, bus.ctrl_e} !== '0) begin
            errors++; $display("FAIL reset_exec: got pc_e=%h rd_e=%0d valid_e=%b, required all zero",
                               bus.pc_e, bus.rd_e, bus.valid_e);
        end
        checks++;
        if (bus.stall_cnt !== 0 || bus.flush_cnt !== 0) begin
            errors++; $display("FAIL reset_cnt: got stall=%0d flush=%0d, required 0/0", bus.stall_cnt, bus.flush_cnt);
        end
        bus.stall_ext = 0; #1;
        checks++;
        if (bus.stall_fd !== 1'b0) begin
            errors++; $display("FAIL reset_stall_fd: got %b, required 0", bus.stall_fd);
        end
        rst = 0; clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        checks++;
        if (bus.mem_rd_e !== 1'b1 || bus.rd_e !== 5'd5) begin
            errors++; $display("FAIL lu_load: got mem_rd_e=%b rd_e=%0d, required 1/5", bus.mem_rd_e, bus.rd_e);
        end
        set_dec(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        #1;
        checks++;
        if (bus.stall_fd !== 1'b1) begin
            errors++; $display("FAIL lu_stall_fd: got %b, required 1", bus.stall_fd);
        end
        tick();
        checks++;
        if (bus.valid_e !== 1'b0 || bus.stall_cnt !== 1 || bus.stall_fd !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: got valid_e=%b stall_cnt=%0d stall_fd=%b, required 0/1/0",
                               bus.valid_e, bus.stall_cnt, bus.stall_fd);
        end
        tick();
        checks++;
        if (bus.valid_e !== 1'b1 || bus.rs1_e !== 5'd5 || bus.rd_e !== 5'd6 || bus.stall_cnt !== 1) begin
            errors++; $display("FAIL lu_dep_load: got valid_e=%b rs1_e=%0d rd_e=%0d stall_cnt=%0d, required 1/5/6/1",
                               bus.valid_e, bus.rs1_e, bus.rd_e, bus.stall_cnt);
        end
    endtask

    task automatic test_x0_unused();
        do_reset();
        set_dec(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
        tick();
        checks++;
        if (bus.w_en_e !== 1'b0 || bus.mem_rd_e !== 1'b1) begin
            errors++; $display("FAIL x0_wen: got w_en_e=%b mem_rd_e=%b, required 0/1", bus.w_en_e, bus.mem_rd_e);
        end
        set_dec(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
        #1;
        checks++;
        if (bus.stall_fd !== 1'b0) begin
            errors++; $display("FAIL x0_no_stall: got %b, required 0", bus.stall_fd);
        end
        tick();
        set_dec(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_dec(1, 5'd3, 1, 5'd5, 0, 5'd8, 1, 0);
        #1;
        checks++;
        if (bus.stall_fd !== 1'b0) begin
            errors++; $display("FAIL unused_no_stall: got %b, required 0", bus.stall_fd);
        end
        tick();
        checks++;
        if (bus.rs2_e !== 5'd0 || bus.valid_e !== 1'b1 || bus.stall_cnt !== 0) begin
            errors++; $display("FAIL unused_rs2: got rs2_e=%0d valid_e=%b stall_cnt=%0d, required 0/1/0",
                               bus.rs2_e, bus.valid_e, bus.stall_cnt);
        end
    endtask

    task automatic test_wb_bypass();
        do_reset();
        set_dec(1, 5'd3, 0, 5'd7, 1, 5'd4, 1, 0);
        bus.rs1_data_d = 32'h1111; bus.rs2_data_d = 32'h0;
        bus.w_en_w = 1; bus.wb_idx_w = 5'd7; bus.wb_data_w = 32'hDEADBEEF;
        tick();
        checks++;
        if (bus.rs2_data_e !== 32'hDEADBEEF || bus.rs1_data_e !== 32'h1111) begin
            errors++; $display("FAIL wb_bypass: got rs2_data_e=%h rs1_data_e=%h, required deadbeef/00001111",
                               bus.rs2_data_e, bus.rs1_data_e);
        end
        bus.rs2_d = 5'd0; bus.rs2_data_d = 32'h1234; bus.wb_idx_w = 5'd0;
        tick();
        checks++;
        if (bus.rs2_data_e !== 32'h1234) begin
            errors++; $display("FAIL wb_x0_no_bypass: got %h, required 00001234", bus.rs2_data_e);
        end
    endtask

    task automatic test_flush_vs_luh();
        do_reset();
        set_dec(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_dec(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        bus.flush = 1;
        #1;
        checks++;
        if (bus.stall_fd !== 1'b0) begin
            errors++; $display("FAIL flush_luh_stall_fd: got %b, required 0", bus.stall_fd);
        end
        tick();
        checks++;
        if (bus.valid_e !== 1'b0 || bus.flush_cnt !== 1 || bus.stall_cnt !== 0) begin
            errors++; $display("FAIL flush_luh: got valid_e=%b flush_cnt=%0d stall_cnt=%0d, required 0/1/0",
                               bus.valid_e, bus.flush_cnt, bus.stall_cnt);
        end
        bus.flush = 0;
    endtask

    task automatic test_freeze();
        do_reset();
        set_dec(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        bus.pc_d = 32'h100; bus.imm_d = 32'h55;
        tick();
        bus.stall_ext = 1; bus.flush = 1;
        for (int i = 0; i < 3; i++) begin
            set_dec(1, 5'(i + 10), 1, 5'(i + 11), 1, 5'(i + 12), 1, 1);
            bus.pc_d = $urandom; bus.imm_d = $urandom;
            #1;
            checks++;
            if (bus.stall_fd !== 1'b1) begin
                errors++; $display("FAIL freeze_stall_fd[%0d]: got %b, required 1", i, bus.stall_fd);
            end
            tick();
            checks++;
            if (bus.valid_e !== 1'b1 || bus.pc_e !== 32'h100 || bus.rd_e !== 5'd9 || bus.imm_e !== 32'h55 ||
                bus.flush_cnt !== 0 || bus.stall_cnt !== 0) begin
                errors++; $display("FAIL freeze_hold[%0d]: got valid_e=%b pc_e=%h rd_e=%0d imm_e=%h flush_cnt=%0d, required 1/100/9/55/0",
                                   i, bus.valid_e, bus.pc_e, bus.rd_e, bus.imm_e, bus.flush_cnt);
            end
        end
        bus.stall_ext = 0;
        #1;
        checks++;
        if (bus.stall_fd !== 1'b0) begin
            errors++; $display("FAIL freeze_release_stall_fd: got %b, required 0", bus.stall_fd);
        end
        tick();
        checks++;
        if (bus.valid_e !== 1'b0 || bus.flush_cnt !== 1) begin
            errors++; $display("FAIL freeze_then_flush: got valid_e=%b flush_cnt=%0d, required 0/1", bus.valid_e, bus.flush_cnt);
        end
        bus.flush = 0;
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        do_reset();
        set_dec(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_dec(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
        #1; if (bus.stall_fd) stalls++;
        tick();
        set_dec(1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0);
        #1; if (bus.stall_fd) stalls++;
        tick();
        checks++;
        if (stalls != 0 || bus.stall_cnt !== 0 || bus.rs1_e !== 5'd5 || bus.valid_e !== 1'b1) begin
            errors++; $display("FAIL two_slot_dep: got stalls=%0d stall_cnt=%0d rs1_e=%0d valid_e=%b, required 0/0/5/1",
                               stalls, bus.stall_cnt, bus.rs1_e, bus.valid_e);
        end
    endtask

    // Reference model: the execute slot is a record of the last accepted instruction.
    task automatic test_random();
        logic              m_valid, m_w_en, m_mem_rd;
        logic [XLEN-1:0]   m_pc, m_d1, m_d2, m_imm;
        logic [4:0]        m_rs1, m_rs2, m_rd;
        logic [CTRL_W-1:0] m_ctrl;
        logic [CNT_W-1:0]  m_scnt, m_fcnt;
        logic              hazard, exp_stall, bubble;
        do_reset();
        {m_valid, m_w_en, m_mem_rd, m_pc, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl} = '0;
        m_scnt = 0; m_fcnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.stall_ext = ($urandom_range(0, 9) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.valid_d = ($urandom_range(0, 3) != 0);
            bus.pc_d = $urandom; bus.imm_d = $urandom; bus.ctrl_d = 16'($urandom);
            bus.rs1_d = 5'($urandom_range(0, 7)); bus.rs2_d = 5'($urandom_range(0, 7));
            bus.rd_d = 5'($urandom_range(0, 7));
            bus.uses_rs1_d = 1'($urandom); bus.uses_rs2_d = 1'($urandom);
            bus.w_en_d = ($urandom_range(0, 3) != 0); bus.mem_rd_d = 1'($urandom);
            bus.rs1_data_d = $urandom; bus.rs2_data_d = $urandom;
            bus.wb_idx_w = 5'($urandom_range(0, 7)); bus.w_en_w = 1'($urandom); bus.wb_data_w = $urandom;
            #1;
            hazard = m_valid && m_mem_rd && m_w_en && bus.valid_d &&
                     ((bus.uses_rs1_d && bus.rs1_d == m_rd) || (bus.uses_rs2_d && bus.rs2_d == m_rd));
            exp_stall = bus.stall_ext || (hazard && !bus.flush);
            checks++;
            if (bus.stall_fd !== exp_stall) begin
                errors++; $display("FAIL rnd_stall_fd @%0d: got %b, required %b", cyc, bus.stall_fd, exp_stall);
            end
            bubble = 0;
            if (rst) begin
                bubble = 1; m_scnt = 0; m_fcnt = 0;
            end else if (bus.stall_ext) begin
            end else if (bus.flush) begin
                bubble = 1; m_fcnt++;
            end else if (hazard) begin
                bubble = 1; m_scnt++;
            end else begin
                m_valid = bus.valid_d; m_pc = bus.pc_d; m_imm = bus.imm_d; m_ctrl = bus.ctrl_d;
                m_rs1 = bus.uses_rs1_d ? bus.rs1_d : 5'd0;
                m_rs2 = bus.uses_rs2_d ? bus.rs2_d : 5'd0;
                m_rd = bus.rd_d;
                m_w_en = bus.valid_d && bus.w_en_d && bus.rd_d != 0;
                m_mem_rd = bus.valid_d && bus.mem_rd_d;
                m_d1 = (bus.w_en_w && bus.wb_idx_w != 0 && bus.wb_idx_w == bus.rs1_d) ? bus.wb_data_w : bus.rs1_data_d;
                m_d2 = (bus.w_en_w && bus.wb_idx_w != 0 && bus.wb_idx_w == bus.rs2_d) ? bus.wb_data_w : bus.rs2_data_d;
            end
            if (bubble)
                {m_valid, m_w_en, m_mem_rd, m_pc, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl} = '0;
            tick();
            checks++;
            if ({bus.valid_e, bus.pc_e, bus.rs1_e, bus.rs2_e, bus.rd_e, bus.w_en_e, bus.mem_rd_e,
                 bus.rs1_data_e, bus.rs2_data_e, bus.imm_e, bus.ctrl_e} !==
                {m_valid, m_pc, m_rs1, m_rs2, m_rd, m_w_en, m_mem_rd, m_d1, m_d2, m_imm, m_ctrl}) begin
                errors++; $display("FAIL rnd_exec @%0d: got v=%b pc=%h rs1=%0d rs2=%0d rd=%0d wen=%b mrd=%b d1=%h d2=%h, required v=%b pc=%h rs1=%0d rs2=%0d rd=%0d wen=%b mrd=%b d1=%h d2=%h",
                                   cyc, bus.valid_e, bus.pc_e, bus.rs1_e, bus.rs2_e, bus.rd_e, bus.w_en_e, bus.mem_rd_e,
                                   bus.rs1_data_e, bus.rs2_data_e, m_valid, m_pc, m_rs1, m_rs2, m_rd, m_w_en, m_mem_rd, m_d1, m_d2);
            end
            checks++;
            if (bus.stall_cnt !== m_scnt || bus.flush_cnt !== m_fcnt) begin
                errors++; $display("FAIL rnd_cnt @%0d: got stall=%0d flush=%0d, required %0d/%0d",
                                   cyc, bus.stall_cnt, bus.flush_cnt, m_scnt, m_fcnt);
            end
        end
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_x0_unused();
        test_wb_bypass();
        test_flush_vs_luh();
        test_freeze();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the RISC-V core. Captures the decoded instruction and its register operands, and produces the execute-stage register indices and write-enables consumed by the forwarding unit. It also handles load-use hazard detection (bubble plus fetch/decode stall), branch flush, external freeze, a writeback-to-decode operand bypass, and stall/flush performance counters.

## Interface

- XLEN, 32, datapath width
- CTRL_W, 16, width of opaque ALU/branch/memory control bundle
- CNT_W, 32, width of performance counters

- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid_d  in  1  decode stage holds a real instruction
- i_pc_d  in  XLEN  decode PC
- i_rs1_d, i_rs2_d  in  5 each  source register indices
- i_uses_rs1_d, i_uses_rs2_d  in  1 each  instruction actually reads rs1/rs2
- i_rd_d  in  5  destination index
- i_w_en_d  in  1  instruction writes rd
- i_mem_rd_d  in  1  instruction is a load
- i_rs1_data_d, i_rs2_data_d  in  XLEN each  register-file read data
- i_imm_d  in  XLEN  immediate
- i_ctrl_d  in  CTRL_W  control bundle
- i_wb_idx_w, i_w_en_w, i_wb_data_w  in  5/1/XLEN  writeback port, the same cycle the register file is written
- i_flush  in  1  taken branch/jump resolved in execute; kill decode instruction
- i_stall_ext  in  1  freeze whole pipeline (memory busy)
- o_valid_e, o_pc_e, o_rs1_e, o_rs2_e, o_rd_e, o_w_en_e, o_mem_rd_e, o_rs1_data_e, o_rs2_data_e, o_imm_e, o_ctrl_e  out  registered execute-stage copies, same widths as inputs
- o_stall_fd  out  1  hold PC and IF/ID register this cycle
- o_stall_cnt, o_flush_cnt  out  CNT_W each  performance counters

## Operation

- Per-cycle action priority, highest first: reset, HOLD, FLUSH, BUBBLE, LOAD.
- Reset: all execute outputs 0 (a bubble); counters 0.
- HOLD (i_stall_ext=1):
  - All execute registers and counters keep their values.
  - o_stall_fd=1.
  - i_flush is ignored; upstream keeps it asserted until the stall clears.
- FLUSH (i_flush=1, no HOLD):
  - Execute registers load a bubble: valid, w_en, mem_rd, rs1, rs2, rd = 0; other fields don't-care, driven 0.
  - o_stall_fd=0.
  - o_flush_cnt increments.
- Load-use hazard (luh) = o_valid_e & o_mem_rd_e & o_w_en_e & i_valid_d & ((i_uses_rs1_d & i_rs1_d==o_rd_e) | (i_uses_rs2_d & i_rs2_d==o_rd_e)).
  - o_rd_e is never 0 while o_w_en_e=1, so x0 never hazards.
- BUBBLE (luh, no HOLD/FLUSH):
  - Execute registers load a bubble.
  - o_stall_fd=1.
  - o_stall_cnt increments.
- LOAD (otherwise): execute registers capture the decode inputs, with these rules:
  - o_valid_e = i_valid_d.
  - o_w_en_e = i_valid_d & i_w_en_d & (i_rd_d != 0).
  - o_mem_rd_e = i_valid_d & i_mem_rd_d.
  - o_rs1_e = i_uses_rs1_d ? i_rs1_d : 0; same for rs2. Unused operands therefore never match a forwarding index other than x0.
  - WB bypass: if i_w_en_w & i_wb_idx_w!=0 & i_wb_idx_w==i_rs1_d, then o_rs1_data_e = i_wb_data_w, else i_rs1_data_d. Same for rs2. This covers a register file that reads before it writes.
  - o_stall_fd=0.
- Counters wrap modulo 2^CNT_W with no saturation.

## Timing

- Execute outputs are registered: decode inputs sampled at edge N appear at outputs after edge N, giving 1-cycle latency.
- o_stall_fd is combinational from the current execute registers, the decode inputs, i_flush and i_stall_ext.
  - It must settle in the same cycle.
  - It has no combinational path from i_wb_*.
- A load followed immediately by a dependent instruction costs exactly 1 bubble cycle. The next cycle the load has moved to memory stage, luh=0, and the dependent instruction loads; the forwarding unit then supplies the data from writeback.
- A load followed by a dependent instruction two slots later costs 0 stall cycles.
- Reset asserted mid-stall: the next edge yields a bubble, and o_stall_fd=0 once reset releases (the registers are a bubble, so luh=0).
- i_flush and luh in the same cycle: flush wins; o_stall_fd=0; only o_flush_cnt increments.
- i_stall_ext and luh together: HOLD; o_stall_cnt does not increment.

## Test plan

- Reset: assert i_rst 2 cycles with random inputs -> all outputs 0, counters 0, o_stall_fd=0.
- Load-use: load x5 in execute (o_mem_rd_e=1, o_rd_e=5); decode add x6,x5,x1 (uses_rs1, rs1=5) -> o_stall_fd=1, next cycle o_valid_e=0, o_stall_cnt=1. Following cycle the add loads with o_rs1_e=5.
- x0 / unused operand: load to rd=0 with w_en_d=1 -> o_w_en_e=0; next instruction reading x0 gives no stall. An instruction with uses_rs2=0 and rs2 field 5 after a load x5 gives no stall and o_rs2_e=0.
- WB bypass: i_w_en_w=1, i_wb_idx_w=7, i_wb_data_w=0xDEADBEEF; decode rs2=7 with stale data 0x0 -> o_rs2_data_e=0xDEADBEEF. With i_wb_idx_w=0 the bypass does not occur.
- Flush vs load-use: luh condition plus i_flush=1 -> bubble, o_stall_fd=0, o_flush_cnt +1, o_stall_cnt unchanged.
- Freeze: i_stall_ext=1 for 3 cycles while i_flush=1 and decode inputs change -> outputs and counters constant, o_stall_fd=1. After release, the flush takes effect on the first edge.
